seq_bit_transformer: RTL and testbench
======================================

// Module: seq_bit_transformer
// PURPOSE
//   Parametrised multi-cycle successor to the 8-bit combinational x->y transform stage.
//   Accepts one WIDTH-bit word with a mode/amount tag and iterates one bit-step per clock.
//   Modes: rotate-left, rotate-right, bit-reverse, gray-encode.
//   Valid/ready on both sides; sits between a word source and a consumer.
// PARAMETERS
//   WIDTH   8   data width; power of two, >= 2
//   AMT_W   3   rotate-amount width; must equal log2(WIDTH)
//   CNT_W   4   step-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        asynchronous, active-high reset
//   x          in   WIDTH    input word
//   mode       in   2        00 rotl, 01 rotr, 10 reverse, 11 gray
//   amt        in   AMT_W    rotate amount; ignored for modes 10/11
//   in_valid   in   1        x/mode/amt valid
//   in_ready   out  1        block can accept a word
//   y          out  WIDTH    result word
//   out_valid  out  1        y valid
//   out_ready  in   1        consumer takes y
//   busy       out  1        high in RUN or DONE
// BEHAVIOUR
//   Reset: state=IDLE; y=0, out_valid=0, busy=0, in_ready=1; internal regs cleared.
//   Async reset mid-RUN/DONE aborts the word; no output for it.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. Accept on in_valid & in_ready: latch x into src, mode, amt.
//     rotl/rotr, amt=0: go directly to DONE, y=x.
//     rotl/rotr, amt>0: cnt=amt, go RUN.
//     reverse: res=0, cnt=WIDTH, go RUN.
//     gray: cnt=1, go RUN.
//   RUN: in_ready=0, out_valid=0. Each cycle:
//     rotl: src={src[W-2:0],src[W-1]}.
//     rotr: src={src[0],src[W-1:1]}.
//     reverse: res={res[W-2:0],src[0]}; src=src>>1.
//     gray: res=src^(src>>1).
//     cnt decrements. When cnt reaches 0 in that cycle: y<=result, go DONE.
//   DONE: out_valid=1, y held stable, in_ready=0.
//     out_valid & out_ready -> IDLE next cycle, out_valid=0, y keeps last value.
//   Latency, accept edge to out_valid high: rot amt=k>0 -> k+1 cycles; rot amt=0 -> 1;
//     reverse -> WIDTH+1; gray -> 2.
//   One word in flight; no accept in DONE, even when out_ready is high.
//   Next word accepted no earlier than the cycle after the DONE handshake.
//   Inputs x/mode/amt are sampled only at accept; later changes have no effect.
//   out_ready is don't-care outside DONE.
//   busy = (state != IDLE).
//   All arithmetic is modulo WIDTH bits; no overflow or status flags.
// TESTING
//   rotl x=8'b10101010 amt=3 -> y=8'b01010101, out_valid exactly 4 cycles after accept.
//   rotr x=8'b00000001 amt=1 -> y=8'b10000000 at 2 cycles.
//   rotl amt=0 x=8'hA5 -> y=8'hA5 at 1 cycle.
//   reverse x=8'b11001100 -> y=8'b00110011 at 9 cycles.
//   gray x=8'b11001100 -> y=8'b10101010 at 2 cycles.
//   Backpressure: hold out_ready=0 for 5 cycles in DONE, in_valid=1 throughout.
//     Expect y stable, in_ready=0, no new accept.
//     After out_ready=1: IDLE on next cycle, then the pending word is accepted.
//   Reset: assert rst at RUN cycle 4 of a reverse.
//     Expect y=0, out_valid=0, busy=0, in_ready=1 immediately.
//     Next word then processes normally.
//   WIDTH=16 instance (AMT_W=4, CNT_W=5): reverse 16'h0001 -> 16'h8000 at 17 cycles.

Source files
------------

// File: rtl/seq_bit_transformer.sv
// seq_bit_transformer: multi-cycle word transform, one bit-step per clock.
// Modes: rotate-left, rotate-right, bit-reverse, gray-encode; valid/ready both sides.
module seq_bit_transformer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_src;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_y;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_src_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] w_result;
  logic             w_accept;
  logic             w_rot_zero;
  logic             w_last;

  // A zero-amount rotate is already finished at accept time.
  assign w_rot_zero = ~mode[1] & (amt == '0);
  assign w_accept   = in_valid & in_ready;
  // Counter at one means this RUN cycle brings it to zero.
  assign w_last     = (r_state == S_RUN) && (r_cnt == CNT_W'(1));
  assign y          = r_y;

  // One bit-step of the latched operation; rotates live in src, the rest in res.
  always_comb begin
    w_src_nxt = r_src;
    w_res_nxt = r_res;
    case (r_mode)
      2'b00: w_src_nxt = {r_src[WIDTH-2:0], r_src[WIDTH-1]};
      2'b01: w_src_nxt = {r_src[0], r_src[WIDTH-1:1]};
      2'b10: begin
        w_res_nxt = {r_res[WIDTH-2:0], r_src[0]};
        w_src_nxt = r_src >> 1;
      end
      default: w_res_nxt = r_src ^ (r_src >> 1);
    endcase
    w_result = r_mode[1] ? w_res_nxt : w_src_nxt;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = w_rot_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture at accept, stepping in RUN, result load on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src  <= '0;
      r_res  <= '0;
      r_y    <= '0;
      r_mode <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_src  <= x;
      r_res  <= '0;
      r_mode <= mode;
      if (w_rot_zero) begin
        r_y   <= x;
        r_cnt <= '0;
      end else if (mode == 2'b10) begin
        r_cnt <= CNT_W'(WIDTH);
      end else if (mode == 2'b11) begin
        r_cnt <= CNT_W'(1);
      end else begin
        r_cnt <= CNT_W'(amt);
      end
    end else if (r_state == S_RUN) begin
      r_src <= w_src_nxt;
      r_res <= w_res_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last) r_y <= w_result;
    end
  end

endmodule

// File: tb/tb_seq_bit_transformer.sv
// tb_seq_bit_transformer: random + directed checks of seq_bit_transformer
// against an arithmetic reference model, 8-bit and 16-bit instances.
module tb_seq_bit_transformer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  x8;
  logic [1:0]  mode8;
  logic [2:0]  amt8;
  logic        iv8;
  logic        ir8;
  logic [7:0]  y8;
  logic        ov8;
  logic        or8;
  logic        busy8;
  logic [15:0] x16;
  logic [1:0]  mode16;
  logic [3:0]  amt16;
  logic        iv16;
  logic        ir16;
  logic [15:0] y16;
  logic        ov16;
  logic        or16;
  logic        busy16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_bit_transformer #(.WIDTH(8), .AMT_W(3), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .x(x8), .mode(mode8), .amt(amt8),
    .in_valid(iv8), .in_ready(ir8), .y(y8), .out_valid(ov8),
    .out_ready(or8), .busy(busy8)
  );

  seq_bit_transformer #(.WIDTH(16), .AMT_W(4), .CNT_W(5)) u_dut16 (
    .clk(clk), .rst(rst), .x(x16), .mode(mode16), .amt(amt16),
    .in_valid(iv16), .in_ready(ir16), .y(y16), .out_valid(ov16),
    .out_ready(or16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model(input int w, input int m, input int a,
                               input int v);
    int mask;
    int r;
    mask = (1 << w) - 1;
    v    = v & mask;
    r    = 0;
    case (m)
      0: r = ((v << a) | (v >> (w - a))) & mask;
      1: r = ((v >> a) | (v << (w - a))) & mask;
      2: for (int i = 0; i < w; i++) r = r | (((v >> i) & 1) << (w - 1 - i));
      default: r = v ^ (v >> 1);
    endcase
    return r;
  endfunction

  function automatic int lat_model(input int w, input int m, input int a);
    if (m < 2) return (a == 0) ? 1 : a + 1;
    if (m == 2) return w + 1;
    return 2;
  endfunction

  task automatic run8(input int m, input int a, input int v, input int hold);
    int n;
    int lat;
    int ey;
    int el;
    logic [7:0] ycap;
    ey = model(8, m, a, v);
    el = lat_model(8, m, a);
    @(negedge clk);
    x8 = v[7:0]; mode8 = m[1:0]; amt8 = a[2:0]; iv8 = 1'b1; or8 = 1'b0;
    n = 0;
    while (!ir8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready8", 32'(ir8), 32'd1);
    @(posedge clk);
    #1;
    iv8 = 1'b0; x8 = 8'($urandom); mode8 = 2'($urandom); amt8 = 3'($urandom);
    lat = 1;
    while (!ov8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("lat8", 32'(lat), 32'(el));
    chk("y8", 32'(y8), 32'(ey));
    chk("done_inready8", 32'(ir8), 32'd0);
    chk("done_busy8", 32'(busy8), 32'd1);
    ycap = y8;
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold_ov8", 32'(ov8), 32'd1);
      chk("hold_y8", 32'(y8), 32'(ycap));
    end
    @(negedge clk);
    or8 = 1'b1;
    @(posedge clk);
    #1;
    chk("post_ov8", 32'(ov8), 32'd0);
    chk("post_ir8", 32'(ir8), 32'd1);
    chk("post_busy8", 32'(busy8), 32'd0);
    chk("post_y8", 32'(y8), 32'(ycap));
    @(negedge clk);
    or8 = 1'b0;
  endtask

  task automatic run16(input int m, input int a, input int v);
    int lat;
    @(negedge clk);
    x16 = v[15:0]; mode16 = m[1:0]; amt16 = a[3:0]; iv16 = 1'b1; or16 = 1'b0;
    chk("accept_ready16", 32'(ir16), 32'd1);
    @(posedge clk);
    #1;
    iv16 = 1'b0; x16 = 16'($urandom);
    lat = 1;
    while (!ov16 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("lat16", 32'(lat), 32'(lat_model(16, m, a)));
    chk("y16", 32'(y16), 32'(model(16, m, a, v)));
    @(negedge clk);
    or16 = 1'b1;
    @(posedge clk);
    #1;
    chk("post_ir16", 32'(ir16), 32'd1);
    @(negedge clk);
    or16 = 1'b0;
  endtask

  task automatic backpressure8();
    int lat;
    logic [7:0] ycap;
    @(negedge clk);
    x8 = 8'h96; mode8 = 2'b00; amt8 = 3'd2; iv8 = 1'b1; or8 = 1'b0;
    chk("bp_ready", 32'(ir8), 32'd1);
    @(posedge clk);
    #1;
    x8 = 8'h3C; mode8 = 2'b11; amt8 = 3'd5;
    lat = 1;
    while (!ov8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_lat_a", 32'(lat), 32'd3);
    chk("bp_y_a", 32'(y8), 32'(model(8, 0, 2, 'h96)));
    ycap = y8;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_hold_ov", 32'(ov8), 32'd1);
      chk("bp_hold_ir", 32'(ir8), 32'd0);
      chk("bp_hold_busy", 32'(busy8), 32'd1);
      chk("bp_hold_y", 32'(y8), 32'(ycap));
    end
    @(negedge clk);
    or8 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_ir", 32'(ir8), 32'd1);
    chk("bp_idle_ov", 32'(ov8), 32'd0);
    @(negedge clk);
    or8 = 1'b0;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    chk("bp_b_busy", 32'(busy8), 32'd1);
    lat = 1;
    while (!ov8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_lat_b", 32'(lat), 32'd2);
    chk("bp_y_b", 32'(y8), 32'(model(8, 3, 0, 'h3C)));
    @(negedge clk);
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    x8 = 8'hCC; mode8 = 2'b10; amt8 = 3'd0; iv8 = 1'b1; or8 = 1'b0;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rr_busy_before", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_y", 32'(y8), 32'd0);
    chk("rr_ov", 32'(ov8), 32'd0);
    chk("rr_busy", 32'(busy8), 32'd0);
    chk("rr_ir", 32'(ir8), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run8(2, 0, 'hCC, 1);
  endtask

  initial begin
    rst = 1'b1;
    x8 = '0; mode8 = '0; amt8 = '0; iv8 = 1'b0; or8 = 1'b0;
    x16 = '0; mode16 = '0; amt16 = '0; iv16 = 1'b0; or16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", 32'(y8), 32'd0);
    chk("rst_ov", 32'(ov8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_ir", 32'(ir8), 32'd1);
    chk("rst_ir16", 32'(ir16), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    run8(0, 3, 'hAA, 0);
    chk("dir_rotl", 32'(y8), 32'h55);
    run8(1, 1, 'h01, 1);
    chk("dir_rotr", 32'(y8), 32'h80);
    run8(0, 0, 'hA5, 2);
    chk("dir_rot0", 32'(y8), 32'hA5);
    run8(2, 0, 'hCC, 0);
    chk("dir_rev", 32'(y8), 32'h33);
    run8(3, 0, 'hCC, 0);
    chk("dir_gray", 32'(y8), 32'hAA);

    backpressure8();
    reset_mid_run();

    for (int i = 0; i < 40; i++) begin
      run8(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    run16(2, 0, 'h0001);
    chk("dir_rev16", 32'(y16), 32'h8000);
    for (int i = 0; i < 12; i++) begin
      run16(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 65535)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
